// File: rtl/fpadd_pkg.sv
// Shared types and format-derived constants for the iterative FP adder.
// Constant helpers return a 64-bit pattern; callers slice to their word width.
// Exponent bias, infinity and canonical quiet-NaN are all derived from EXP_W/MAN_W.
package fpadd_pkg;

  typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, ADD, NORM, ROUND} state_t;

  typedef enum logic [1:0] {CLS_ZERO, CLS_NORM, CLS_INF, CLS_NAN} fp_class_t;

  localparam int PAT_W = 64;

  function automatic logic [PAT_W-1:0] exp_bias(input int exp_w);
    return (PAT_W'(1) << (exp_w - 1)) - PAT_W'(1);
  endfunction

  // Positive infinity: exponent all ones, fraction zero.
  function automatic logic [PAT_W-1:0] inf_pat(input int exp_w, input int man_w);
    return ((PAT_W'(1) << exp_w) - PAT_W'(1)) << man_w;
  endfunction

  // Canonical quiet NaN: sign 0, exponent all ones, only the fraction MSB set.
  function automatic logic [PAT_W-1:0] qnan_pat(input int exp_w, input int man_w);
    return inf_pat(exp_w, man_w) | (PAT_W'(1) << (man_w - 1));
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// Leading-zero counter for the normalisation step.
// Latency: combinational.
// Backpressure: none; an all-zero input yields 0 (zero results are flagged separately).
module fp_lzc #(
  parameter int N  = 27,
  parameter int CW = $clog2(N)
) (
  input  logic [N-1:0]  din,
  output logic [CW-1:0] cnt
);

  // Scan upward so the highest set bit is the last to write the count.
  always_comb begin
    cnt = '0;
    for (int i = 0; i < N; i++) begin
      if (din[i]) cnt = CW'(N - 1 - i);
    end
  end

endmodule

// File: rtl/fpadd_pipe_param.sv
// Parametrised IEEE-754-style adder/subtractor, one FSM step per cycle, RNE, flush-to-zero.
// Latency: done pulses exactly 5 cycles after the accepting start edge, specials included.
// Backpressure: start is ignored while busy; sum holds until the next accepted start.
module fpadd_pipe_param
  import fpadd_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   sub,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic [EXP_W+MAN_W:0]   sum,
  output logic                   done,
  output logic                   busy
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int SW = MAN_W + 4;            // hidden + fraction + guard/round/sticky
  localparam int CW = $clog2(SW);
  localparam int XW = EXP_W + CW + 2;       // signed headroom for exponent adjust
  localparam logic [EXP_W-1:0]        EXP_ONES  = '1;
  localparam logic [PAT_W-1:0]        QNAN_FULL = qnan_pat(EXP_W, MAN_W);
  localparam logic [W-1:0]            QNAN      = QNAN_FULL[W-1:0];
  localparam logic signed [XW-1:0]    X_ZERO    = '0;
  localparam logic signed [XW-1:0]    X_ONE     = XW'(1);
  localparam logic signed [XW-1:0]    X_INF     = $signed(XW'(EXP_ONES));

  state_t                 state;
  logic [W-1:0]           a_q, b_q;
  logic                   sa_q, sb_q;
  logic [EXP_W-1:0]       ea_q, eb_q;
  logic [MAN_W:0]         ma_q, mb_q;
  fp_class_t              ca_q, cb_q;
  logic                   spec_q;
  logic [W-1:0]           spec_val_q;
  logic                   sign_l_q, sign_s_q;
  logic [EXP_W-1:0]       exp_l_q;
  logic [SW-1:0]          sig_l_q, sig_s_q;
  logic [SW:0]            add_q;
  logic [SW-1:0]          norm_q;
  logic signed [XW-1:0]   nexp_q;
  logic                   zero_q, zsign_q;

  function automatic fp_class_t classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
    if (e == EXP_ONES) return (f != '0) ? CLS_NAN : CLS_INF;
    if (e == '0)       return CLS_ZERO;     // subnormals flush to signed zero
    return CLS_NORM;
  endfunction

  fp_class_t ca_d, cb_d;
  logic [MAN_W:0] ma_d, mb_d;

  // UNPACK: classify operands and restore the hidden bit for normals only.
  always_comb begin
    ca_d = classify(a_q[W-2:MAN_W], a_q[MAN_W-1:0]);
    cb_d = classify(b_q[W-2:MAN_W], b_q[MAN_W-1:0]);
    ma_d = (ca_d == CLS_NORM) ? {1'b1, a_q[MAN_W-1:0]} : '0;
    mb_d = (cb_d == CLS_NORM) ? {1'b1, b_q[MAN_W-1:0]} : '0;
  end

  logic             swap, sl, ss;
  logic [EXP_W-1:0] el, es, diff;
  logic [MAN_W:0]   ml, ms;
  logic [2*SW-1:0]  ext;
  logic [SW-1:0]    small_d;
  logic             spec_d;
  logic [W-1:0]     spec_val_d;

  // ALIGN: order by magnitude, shift the smaller significand keeping a sticky OR.
  always_comb begin
    swap = {eb_q, mb_q} > {ea_q, ma_q};
    sl   = swap ? sb_q : sa_q;
    ss   = swap ? sa_q : sb_q;
    el   = swap ? eb_q : ea_q;
    es   = swap ? ea_q : eb_q;
    ml   = swap ? mb_q : ma_q;
    ms   = swap ? ma_q : mb_q;
    diff = el - es;
    ext  = {ms, 3'b000, {SW{1'b0}}} >> diff;
    if (32'(diff) >= SW - 1) small_d = {{(SW-1){1'b0}}, |ms};
    else                     small_d = ext[2*SW-1:SW] | {{(SW-1){1'b0}}, |ext[SW-1:0]};
  end

  // Special-operand results bypass the arithmetic path (b_q already carries the sub inversion).
  always_comb begin
    spec_d     = 1'b1;
    spec_val_d = '0;
    if (ca_q == CLS_NAN || cb_q == CLS_NAN)       spec_val_d = QNAN;
    else if (ca_q == CLS_INF && cb_q == CLS_INF)  spec_val_d = (sa_q != sb_q) ? QNAN : a_q;
    else if (ca_q == CLS_INF)                     spec_val_d = a_q;
    else if (cb_q == CLS_INF)                     spec_val_d = b_q;
    else if (ca_q == CLS_ZERO && cb_q == CLS_ZERO) spec_val_d = {sa_q & sb_q, {(W-1){1'b0}}};
    else if (ca_q == CLS_ZERO)                    spec_val_d = b_q;
    else if (cb_q == CLS_ZERO)                    spec_val_d = a_q;
    else                                          spec_d = 1'b0;
  end

  logic [SW:0] add_d;

  // ADD: like signs add, unlike signs subtract smaller from larger.
  always_comb begin
    add_d = (sign_l_q == sign_s_q) ? ({1'b0, sig_l_q} + {1'b0, sig_s_q})
                                   : ({1'b0, sig_l_q} - {1'b0, sig_s_q});
  end

  logic [CW-1:0]        lz;
  logic [SW-1:0]        norm_d;
  logic signed [XW-1:0] exp_ext, nexp_d;
  logic                 zero_d, zsign_d;

  fp_lzc #(.N(SW), .CW(CW)) u_lzc (.din(add_q[SW-1:0]), .cnt(lz));

  // NORM: one-step right shift on carry-out, else left shift by leading zeros.
  always_comb begin
    exp_ext = $signed(XW'(exp_l_q));
    if (add_q[SW]) begin
      norm_d = add_q[SW:1] | {{(SW-1){1'b0}}, add_q[0]};
      nexp_d = exp_ext + X_ONE;
    end else begin
      norm_d = add_q[SW-1:0] << lz;
      nexp_d = exp_ext - XW'(lz);
    end
    // Exact cancellation gives +0; exponent underflow flushes to the result's signed zero.
    zero_d  = (add_q == '0) || (nexp_d <= X_ZERO);
    zsign_d = (add_q == '0) ? 1'b0 : sign_l_q;
  end

  logic                 rup;
  logic [MAN_W+1:0]     mant;
  logic signed [XW-1:0] rexp;
  logic [MAN_W-1:0]     frac;
  logic [W-1:0]         res_d;

  // ROUND: nearest-even on G/R/S; a carry out leaves 1.000.. so shift once and bump the exponent.
  always_comb begin
    rup  = norm_q[2] & (norm_q[1] | norm_q[0] | norm_q[3]);
    mant = {1'b0, norm_q[SW-1:3]} + {{(MAN_W+1){1'b0}}, rup};
    rexp = nexp_q + (mant[MAN_W+1] ? X_ONE : X_ZERO);
    frac = mant[MAN_W+1] ? mant[MAN_W:1] : mant[MAN_W-1:0];
    if (spec_q)             res_d = spec_val_q;
    else if (zero_q)        res_d = {zsign_q, {(W-1){1'b0}}};
    else if (rexp >= X_INF) res_d = {sign_l_q, EXP_ONES, {MAN_W{1'b0}}};
    else                    res_d = {sign_l_q, rexp[EXP_W-1:0], frac};
  end

  // Sequencer: each state loads its own register bank; reset aborts without a done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;  sum <= '0;  done <= 1'b0;  busy <= 1'b0;
      a_q <= '0;  b_q <= '0;
      sa_q <= 1'b0;  sb_q <= 1'b0;  ea_q <= '0;  eb_q <= '0;  ma_q <= '0;  mb_q <= '0;
      ca_q <= CLS_ZERO;  cb_q <= CLS_ZERO;
      spec_q <= 1'b0;  spec_val_q <= '0;
      sign_l_q <= 1'b0;  sign_s_q <= 1'b0;  exp_l_q <= '0;  sig_l_q <= '0;  sig_s_q <= '0;
      add_q <= '0;  norm_q <= '0;  nexp_q <= '0;  zero_q <= 1'b0;  zsign_q <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (start && !busy) begin
            a_q   <= a;
            b_q   <= {b[W-1] ^ sub, b[W-2:0]};
            busy  <= 1'b1;
            state <= UNPACK;
          end
        end
        UNPACK: begin
          sa_q <= a_q[W-1];  ea_q <= a_q[W-2:MAN_W];  ma_q <= ma_d;  ca_q <= ca_d;
          sb_q <= b_q[W-1];  eb_q <= b_q[W-2:MAN_W];  mb_q <= mb_d;  cb_q <= cb_d;
          state <= ALIGN;
        end
        ALIGN: begin
          spec_q   <= spec_d;  spec_val_q <= spec_val_d;
          sign_l_q <= sl;      sign_s_q   <= ss;
          exp_l_q  <= el;
          sig_l_q  <= {ml, 3'b000};
          sig_s_q  <= small_d;
          state    <= ADD;
        end
        ADD: begin
          add_q <= add_d;
          state <= NORM;
        end
        NORM: begin
          norm_q <= norm_d;  nexp_q <= nexp_d;  zero_q <= zero_d;  zsign_q <= zsign_d;
          state  <= ROUND;
        end
        ROUND: begin
          sum   <= res_d;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fpadd_pipe_param.md
FPADD_PIPE_PARAM -- requirements
Module: fpadd_pipe_param

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width.
REQ-002 SHALL have parameter MAN_W, default 23, stored mantissa (fraction) width; W = 1+EXP_W+MAN_W.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  single-cycle request; operands sampled on the same edge.
REQ-006 SHALL have port sub  input  1  mode: 0 = a+b, 1 = a-b (b sign inverted at capture).
REQ-007 SHALL have port a  input  W  IEEE-754-style operand A.
REQ-008 SHALL have port b  input  W  IEEE-754-style operand B.
REQ-009 SHALL have port sum  output  W  result, held stable from done until the next accepted start.
REQ-010 SHALL have port done  output  1  one-cycle pulse marking a valid sum.
REQ-011 SHALL have port busy  output  1  high from the cycle after an accepted start through the done cycle.

Function
REQ-012 SHALL use FSM states IDLE, UNPACK, ALIGN, ADD, NORM, ROUND; done is asserted on the ROUND->IDLE transition.
REQ-013 SHALL accept start only when busy=0; start while busy SHALL be ignored with no effect on the operation in flight.
REQ-014 SHALL have a fixed latency: done asserts exactly 5 cycles after the start edge, for every operand class, specials included.
REQ-015 UNPACK SHALL split sign, exponent and fraction, add the hidden 1 for normal operands, and classify each operand as zero, normal, inf or NaN.
REQ-016 Subnormal inputs (exp=0, frac!=0) SHALL be treated as signed zero (flush-to-zero).
REQ-017 ALIGN SHALL swap operands so that |A|>=|B|, then right-shift B's significand by the exponent difference, keeping guard, round and sticky bits; shifts >= MAN_W+3 SHALL reduce B to sticky only.
REQ-018 ADD SHALL add significands when signs are equal and subtract (larger minus smaller) otherwise, in MAN_W+5 bits with a carry bit; the result sign is the sign of the larger operand.
REQ-019 NORM SHALL, in one cycle, right-shift by 1 on carry-out, or left-shift by the leading-zero count, and adjust the exponent accordingly.
REQ-020 ROUND SHALL apply round-to-nearest-even on guard/round/sticky and renormalise if rounding carries out of the significand.
REQ-021 An exact zero result from cancellation SHALL be +0; (+0)+(+0) = +0; (-0)+(-0) = -0.
REQ-022 Exponent >= 2^EXP_W-1 after rounding SHALL produce a correctly signed infinity.
REQ-023 Exponent <= 0 after normalisation SHALL produce a signed zero (flush-to-zero output).
REQ-024 Any NaN operand, or inf + (-inf) after the sub inversion, SHALL produce canonical qNaN: sign 0, exponent all-ones, fraction MSB 1, other fraction bits 0.
REQ-025 inf combined with a finite operand SHALL return that inf; zero combined with x SHALL return x (after the sub inversion of b).

Reset
REQ-026 With reset high at a clock edge: state = IDLE, sum = 0, done = 0, busy = 0, all internal registers cleared.
REQ-027 Reset SHALL take priority over start and SHALL abort an operation in flight, with no done pulse for it.

Structure
REQ-028 A shared package fpadd_pkg SHALL hold the FSM state enum, the operand-class enum, and functions/constants derived from EXP_W/MAN_W (qNaN pattern, exponent bias, infinity pattern).
REQ-029 Leading-zero counting SHALL be a separate parametrised combinational sub-module fp_lzc (input width MAN_W+4, output count width clog2).

Verification
REQ-030 Default params: a=0x3F800000, b=0x3F800000, sub=0, start -> done exactly 5 cycles later with sum=0x40000000.
REQ-031 a=0x3F800000, b=0x3F800000, sub=1 -> sum=0x00000000; a=0x7F800000, b=0xFF800000, sub=0 -> sum=0x7FC00000.
REQ-032 a=0x7F7FFFFF, b=0x7F7FFFFF -> sum=0x7F800000; a=0x3F800000, b=0x33800000 (tie) -> 0x3F800000; a=0x3F800001, b=0x33800000 -> 0x3F800002.
REQ-033 Reset asserted in the ALIGN cycle -> no done pulse, sum=0, busy=0; a new start 1 cycle later completes normally. Second start pulse issued while busy is ignored.
REQ-034 EXP_W=5, MAN_W=10: a=0x3C00, b=0x3C00 -> 0x4000; a=0x7BFF, b=0x7BFF -> 0x7C00; a=0x0001 (subnormal), b=0x3C00 -> 0x3C00.
